evt_pulse_gen: RTL and testbench
================================

Name: evt_pulse_gen

Overview:
- Input conditioner that sits directly upstream of the event counter.
- Takes a raw asynchronous level (button, switch, or external strobe) and synchronises and debounces it.
- Emits single-cycle event pulses on a selected edge, suitable for the counter's event input.
- Also exports the debounced level for display and other logic.

Parameters:
- DEBOUNCE_CYCLES, 20000: consecutive stable synchronised samples needed to accept a level change; legal range 1..65535.
- EDGE_SEL, 0: pulse source. 0 = rising, 1 = falling, 2 = both edges of the debounced level.
- REPEAT_DELAY, 50000000: cycles the level must stay accepted-high before the first auto-repeat pulse. Used only with the optional feature.
- REPEAT_PERIOD, 10000000: cycles between subsequent auto-repeat pulses. Used only with the optional feature.

Ports:
- clk_in  input  1  system clock; all logic is in this single domain.
- rst_in  input  1  asynchronous, active-low reset; asserting it clears all state immediately.
- raw_in  input  1  raw asynchronous level, never used before synchronisation.
- clean_out  output  1  debounced, synchronised level.
- evt_out  output  1  one-cycle event pulse, registered.

Behaviour:
- Reset (rst_in low, async): sync flops, counters and state clear; clean_out=0, evt_out=0, FSM=STABLE_LO. Reset mid-debounce discards progress.
- Reset exit:
  - If raw_in is already high, the block runs a normal debounce and emits a rising event; no special case.
  - Timing of the first transition follows the same 2-edge sync latency plus debounce count as any other change.
- Synchroniser: 2 flops, raw_in -> s1 -> s2. Only s2 feeds the FSM.
- FSM states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
- STABLE_LO:
  - s2=1 -> PEND_HI with cnt=1.
  - If DEBOUNCE_CYCLES==1, go directly to STABLE_HI on that edge.
- PEND_HI:
  - s2=0 -> STABLE_LO, cnt=0 (glitch rejected, no pulse).
  - s2=1 with cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, cnt=0.
  - Otherwise cnt++.
- STABLE_HI and PEND_LO mirror the above with polarity inverted.
- clean_out is registered: 1 exactly when FSM is in STABLE_HI or PEND_LO.
- Latency: raw_in first sampled high at edge k and held -> clean_out and the rising evt_out go high at edge k+1+DEBOUNCE_CYCLES. evt_out drops at the next edge.
- evt_out:
  - Asserted for exactly one cycle on the accepted transition matching EDGE_SEL.
  - Never asserted two cycles in a row.
  - At most one pulse per accepted transition.
- Bounce: any s2 toggle during PEND restarts from the stable state. No partial-count carry-over.
- Counter width: $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1). The counter saturates, never wraps.

Optional Feature:
- Macro: EVT_PULSE_REPEAT_EN.
- Defined (auto-repeat while held in STABLE_HI):
  - First repeat pulse REPEAT_DELAY cycles after the accepted rising edge, then one pulse every REPEAT_PERIOD cycles.
  - Leaving STABLE_HI, or reset, cancels repeat immediately.
  - Repeat pulses are emitted only when EDGE_SEL is 0 or 2.
  - The repeat counter is separate from the debounce counter.
- Undefined: no repeat logic is instantiated; evt_out fires only on accepted transitions. REPEAT_* parameters are ignored.

Decomposition:
- Package evt_pkg holds:
  - Typedef enum logic[1:0] evt_state_t (STABLE_LO, PEND_HI, STABLE_HI, PEND_LO).
  - Constants EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2.
- Sub-module sync_2ff: parameterised width, async active-low reset to 0. Reused elsewhere for other async inputs.

Test Plan:
- DEBOUNCE_CYCLES=4, EDGE_SEL=0, raw_in rises and is sampled at edge 10 and held -> clean_out=1 and evt_out=1 from edge 15; evt_out=0 from edge 16; exactly 1 pulse.
- DEBOUNCE_CYCLES=4, raw_in high for 3 cycles then low, repeated 5 times -> clean_out stays 0, zero pulses.
- DEBOUNCE_CYCLES=4, EDGE_SEL=2, clean high then low transition -> exactly 2 single-cycle pulses, one per accepted edge; EDGE_SEL=1 gives only the falling pulse.
- rst_in driven low while FSM is in PEND_HI with cnt=3 -> outputs 0 immediately (async). After release with raw_in held high, pulse arrives 1+DEBOUNCE_CYCLES edges after the first sample.
- DEBOUNCE_CYCLES=1 -> level accepted 2 edges after the first sample; no double pulse.
- EVT_PULSE_REPEAT_EN, DEBOUNCE_CYCLES=2, REPEAT_DELAY=8, REPEAT_PERIOD=3, raw_in held high for 20 cycles after acceptance:
  - Pulses at acceptance +0, +8, +11, +14, +17.
  - raw_in low cancels further repeats.

Source files
------------

// File: rtl/evt_pulse_gen_pkg.sv
// Shared types and constants for the event pulse generator.
// Edge-select codes, debounce FSM states and a width helper.
package evt_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      PEND_HI   = 2'd1,
      STABLE_HI = 2'd2,
      PEND_LO   = 2'd3
   } evt_state_t;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_BOTH = 2;

   function automatic int unsigned max3(
      input int unsigned a,
      input int unsigned b,
      input int unsigned c
   );
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/evt_pulse_gen_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Both stages reset to zero.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] s1_q;
   logic [WIDTH-1:0] s2_q;

   // two-stage capture of the asynchronous level
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/evt_pulse_gen.sv
// Synchronise, debounce and edge-detect a raw level into event pulses.
// Optional auto-repeat while held high: define EVT_PULSE_REPEAT_EN.
module evt_pulse_gen
   import evt_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 20000,
   parameter int          EDGE_SEL        = 0,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_PERIOD   = 10000000
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic raw_in,
   output logic clean_out,
   output logic evt_out
);

   localparam int unsigned CNT_MAX =
      max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam int CNT_W = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_SAT = '1;
   localparam logic [CNT_W-1:0] DB_LAST =
      CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam bit DB_ONE = (DEBOUNCE_CYCLES == 1);

   logic             s2;
   evt_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clean_q, clean_d;
   logic             evt_q, evt_d;
   logic             rise, fall;
   logic             edge_evt;
   logic             rpt_fire;

   sync_2ff #(
      .WIDTH (1)
   ) u_sync (
      .clk_i  (clk_in),
      .rst_ni (rst_in),
      .d_i    (raw_in),
      .q_o    (s2)
   );

   // debounce FSM: a level change needs DEBOUNCE_CYCLES equal samples
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise    = 1'b0;
      fall    = 1'b0;
      unique case (state_q)
         STABLE_LO: begin
            if (s2) begin
               if (DB_ONE) begin
                  state_d = STABLE_HI;
                  rise    = 1'b1;
               end else begin
                  state_d = PEND_HI;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         PEND_HI: begin
            if (!s2) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
               rise    = 1'b1;
            end else if (cnt_q != CNT_SAT) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STABLE_HI: begin
            if (!s2) begin
               if (DB_ONE) begin
                  state_d = STABLE_LO;
                  fall    = 1'b1;
               end else begin
                  state_d = PEND_LO;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         PEND_LO: begin
            if (s2) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
               fall    = 1'b1;
            end else if (cnt_q != CNT_SAT) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef EVT_PULSE_REPEAT_EN
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
   localparam bit RPT_OK = (EDGE_SEL != EDGE_FALL);

   logic [CNT_W-1:0] rpt_q, rpt_d;
   logic             armed_q, armed_d;

   // repeat timer runs only while staying in STABLE_HI
   always_comb begin
      rpt_d    = rpt_q;
      armed_d  = armed_q;
      rpt_fire = 1'b0;
      if (state_q != STABLE_HI || !s2) begin
         rpt_d   = '0;
         armed_d = 1'b0;
      end else if (rpt_q == (armed_q ? RP_LAST : RD_LAST)) begin
         rpt_d    = '0;
         armed_d  = 1'b1;
         rpt_fire = RPT_OK;
      end else if (rpt_q != CNT_SAT) begin
         rpt_d = rpt_q + CNT_ONE;
      end
   end

   // repeat timer state
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rpt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         rpt_q   <= rpt_d;
         armed_q <= armed_d;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   assign edge_evt = (rise && (EDGE_SEL != EDGE_FALL)) ||
                     (fall && (EDGE_SEL != EDGE_RISE));

   assign clean_d = (state_d == STABLE_HI) || (state_d == PEND_LO);
   assign evt_d   = (edge_evt || rpt_fire) && !evt_q;

   // FSM, counter and registered outputs
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         clean_q <= 1'b0;
         evt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         evt_q   <= evt_d;
      end
   end

   assign clean_out = clean_q;
   assign evt_out   = evt_q;

endmodule

// File: tb/tb_evt_pulse_gen.sv
// Self-checking bench for evt_pulse_gen: five configurations
// driven by one raw level, compared to a sample-window model.
module tb_evt_pulse_gen;

   localparam int N  = 5;
   localparam int DB [N] = '{4, 4, 4, 1, 2};
   localparam int SL [N] = '{0, 1, 2, 2, 0};
   localparam int RD = 8;
   localparam int RP = 3;
`ifdef EVT_PULSE_REPEAT_EN
   localparam bit RPT_EN = 1'b1;
`else
   localparam bit RPT_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic raw   = 1'b0;
   logic [N-1:0] clean;
   logic [N-1:0] evt;

   int checks = 0;
   int errors = 0;

   bit lvl  [N];
   bit pev  [N];
   bit inhi [N];
   int hst  [N];
   bit rawh [$];
   bit s2h  [$];

   always #5 clk = ~clk;

   evt_pulse_gen #(.DEBOUNCE_CYCLES(4), .EDGE_SEL(0)) u0 (
      .clk_in(clk), .rst_in(rst_n), .raw_in(raw),
      .clean_out(clean[0]), .evt_out(evt[0]));
   evt_pulse_gen #(.DEBOUNCE_CYCLES(4), .EDGE_SEL(1)) u1 (
      .clk_in(clk), .rst_in(rst_n), .raw_in(raw),
      .clean_out(clean[1]), .evt_out(evt[1]));
   evt_pulse_gen #(.DEBOUNCE_CYCLES(4), .EDGE_SEL(2)) u2 (
      .clk_in(clk), .rst_in(rst_n), .raw_in(raw),
      .clean_out(clean[2]), .evt_out(evt[2]));
   evt_pulse_gen #(.DEBOUNCE_CYCLES(1), .EDGE_SEL(2)) u3 (
      .clk_in(clk), .rst_in(rst_n), .raw_in(raw),
      .clean_out(clean[3]), .evt_out(evt[3]));
   evt_pulse_gen #(.DEBOUNCE_CYCLES(2), .EDGE_SEL(0),
                   .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u4 (
      .clk_in(clk), .rst_in(rst_n), .raw_in(raw),
      .clean_out(clean[4]), .evt_out(evt[4]));

   task automatic chk(input string tag, input int idx,
                      input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s[%0d] got %b exp %b at %0t",
                tag, idx, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         lvl[i]  = 1'b0;
         pev[i]  = 1'b0;
         inhi[i] = 1'b0;
         hst[i]  = 0;
      end
      rawh.delete();
      s2h.delete();
   endtask

   // one clock edge: drive raw, advance model, compare
   task automatic step(input bit r);
      bit s2, acc, want, rep, ev;
      int n, d;
      raw = r;
      @(posedge clk);
      #1;
      rawh.push_back(r);
      s2 = (rawh.size() >= 3) ? rawh[rawh.size() - 3] : 1'b0;
      s2h.push_back(s2);
      n = s2h.size();
      for (int i = 0; i < N; i++) begin
         acc = (n >= DB[i]);
         if (acc)
            for (int j = 0; j < DB[i]; j++)
               if (s2h[n - 1 - j] == lvl[i]) acc = 1'b0;
         rep = 1'b0;
         if (RPT_EN && i == 4 && lvl[i] && inhi[i] && s2) begin
            d = (n - 1) - hst[i];
            rep = (d >= RD) && (((d - RD) % RP) == 0);
         end
         want = 1'b0;
         if (acc) begin
            want = lvl[i] ? (SL[i] != 0) : (SL[i] != 1);
            lvl[i] = ~lvl[i];
            inhi[i] = lvl[i];
            hst[i] = n - 1;
         end else if (lvl[i]) begin
            if (!s2) inhi[i] = 1'b0;
            else if (!inhi[i]) begin
               inhi[i] = 1'b1;
               hst[i] = n - 1;
            end
         end
         ev = (want || rep) && !pev[i];
         pev[i] = ev;
         chk("clean", i, clean[i], lvl[i]);
         chk("evt", i, evt[i], ev);
      end
   endtask

   task automatic hold(input bit r, input int cyc);
      for (int k = 0; k < cyc; k++) step(r);
   endtask

   // async reset between edges; outputs must drop at once
   task automatic pulse_reset(input int edges);
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < N; i++) begin
         chk("rst_clean", i, clean[i], 1'b0);
         chk("rst_evt", i, evt[i], 1'b0);
      end
      model_clear();
      for (int k = 0; k < edges; k++) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      model_clear();
      rst_n = 1'b0;
      raw = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         chk("por_clean", i, clean[i], 1'b0);
         chk("por_evt", i, evt[i], 1'b0);
      end
      #2;
      rst_n = 1'b1;

      // raw already high out of reset, then a clean low
      hold(1'b1, 12);
      hold(1'b0, 12);

      // single accepted rise and fall
      hold(1'b1, 14);
      hold(1'b0, 14);

      // bounces shorter than the debounce window
      for (int k = 0; k < 5; k++) begin
         hold(1'b1, 3);
         hold(1'b0, 3);
      end
      hold(1'b0, 6);

      // fast toggling for the single-sample configuration
      for (int k = 0; k < 10; k++) step(k[0]);
      hold(1'b0, 8);

      // reset while the 4-cycle debounce is mid-count
      hold(1'b1, 5);
      pulse_reset(0);
      hold(1'b1, 10);
      pulse_reset(2);
      hold(1'b1, 8);

      // long hold for auto-repeat, then release
      hold(1'b0, 10);
      hold(1'b1, 30);
      hold(1'b0, 10);
      hold(1'b1, 14);
      step(1'b0);
      hold(1'b1, 16);
      hold(1'b0, 10);

      // random levels with random hold lengths
      for (int s = 0; s < 250; s++) begin
         if ($urandom_range(0, 24) == 0)
            pulse_reset($urandom_range(0, 2));
         if ($urandom_range(0, 9) == 0)
            hold(1'($urandom_range(0, 1)), $urandom_range(10, 25));
         else
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 6));
      end
      hold(1'b0, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
